// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg: shared constants and PC-source encoding for the CPU core.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cpu_pkg;

    localparam logic [31:0] RESET_PC  = 32'h8000_0000;
    localparam logic [31:0] ILLOP_PC  = 32'h8000_0004;
    localparam logic [31:0] XADR_PC   = 32'h8000_0008;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [2:0] {
        SEQ    = 3'd0,
        BRANCH = 3'd1,
        JUMP   = 3'd2,
        JREG   = 3'd3,
        IRQ    = 3'd4,
        EXC    = 3'd5,
        HOLD   = 3'd6
    } pc_src_t;

    // Bit 31 is the supervisor bit, so the increment carry must stop at bit 30.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_mux: prioritised next-PC selection for the fetch stage.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pc_mux #(
    parameter logic [31:0] ILLOP_PC = cpu_pkg::ILLOP_PC,
    parameter logic [31:0] XADR_PC  = cpu_pkg::XADR_PC
) (
    input  logic               i_branch_taken,
    input  logic [31:0]        i_branch_target,
    input  logic               i_except,
    input  logic               i_jump,
    input  logic               i_jump_reg,
    input  logic [25:0]        i_jump_target,
    input  logic [31:0]        i_jr_target,
    input  logic [3:0]         i_jump_region,
    input  logic               i_stall,
    input  logic               i_irq_take,
    input  logic [31:0]        i_pc,
    output cpu_pkg::pc_src_t   o_src,
    output logic [31:0]        o_next_pc
);
    import cpu_pkg::*;

    logic [31:0] w_pc_plus4;

    assign w_pc_plus4 = pc_inc(i_pc);

    always_comb begin
        o_src     = SEQ;
        o_next_pc = w_pc_plus4;
        if (i_branch_taken) begin
            o_src     = BRANCH;
            o_next_pc = i_branch_target;
        end else if (i_except) begin
            o_src     = EXC;
            o_next_pc = XADR_PC;
        end else if (i_jump && i_jump_reg) begin
            o_src     = JREG;
            o_next_pc = i_jr_target;
        end else if (i_jump) begin
            o_src     = JUMP;
            o_next_pc = {i_jump_region, i_jump_target, 2'b00};
        end else if (i_stall) begin
            o_src     = HOLD;
            o_next_pc = i_pc;
        end else if (i_irq_take) begin
            o_src     = IRQ;
            o_next_pc = ILLOP_PC;
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_stage: PC register, IF/ID pipeline register and interrupt slot.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module if_stage #(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter logic [31:0] ILLOP_PC = cpu_pkg::ILLOP_PC,
    parameter logic [31:0] XADR_PC  = cpu_pkg::XADR_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        irq,
    input  logic        stall,
    input  logic        except,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic [25:0] jump_target,
    input  logic [31:0] jr_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic        id_irq
);
    import cpu_pkg::*;

    logic [31:0] r_pc;
    logic        r_irq_pending;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc_plus4;
    logic        r_id_irq;

    logic [31:0] w_pc_plus4;
    logic        w_irq_take;
    logic        w_user_mode;
    pc_src_t     w_src;
    logic [31:0] w_next_pc;

    assign w_pc_plus4  = pc_inc(r_pc);
    assign w_user_mode = ~r_pc[31];
    assign w_irq_take  = r_irq_pending & w_user_mode;

    pc_mux #(
        .ILLOP_PC (ILLOP_PC),
        .XADR_PC  (XADR_PC)
    ) u_pc_mux (
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .i_except        (except),
        .i_jump          (jump),
        .i_jump_reg      (jump_reg),
        .i_jump_target   (jump_target),
        .i_jr_target     (jr_target),
        .i_jump_region   (r_id_pc_plus4[31:28]),
        .i_stall         (stall),
        .i_irq_take      (w_irq_take),
        .i_pc            (r_pc),
        .o_src           (w_src),
        .o_next_pc       (w_next_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_irq_pending <= 1'b0;
            r_id_instr    <= NOP_INSTR;
            r_id_pc_plus4 <= 32'h0;
            r_id_irq      <= 1'b0;
        end else begin
            r_pc <= w_next_pc;

            // Launching the slot consumes the request even if irq is still high.
            if (w_src == IRQ) begin
                r_irq_pending <= 1'b0;
            end else if (irq && w_user_mode) begin
                r_irq_pending <= 1'b1;
            end

            case (w_src)
                BRANCH, EXC, JREG, JUMP: begin
                    r_id_instr    <= NOP_INSTR;
                    r_id_pc_plus4 <= 32'h0;
                    r_id_irq      <= 1'b0;
                end
                HOLD: begin
                    r_id_instr    <= r_id_instr;
                    r_id_pc_plus4 <= r_id_pc_plus4;
                    r_id_irq      <= r_id_irq;
                end
                IRQ: begin
                    // The current PC is the return address; its fetched word is dropped.
                    r_id_instr    <= NOP_INSTR;
                    r_id_pc_plus4 <= r_pc;
                    r_id_irq      <= 1'b1;
                end
                default: begin
                    r_id_instr    <= imem_rdata;
                    r_id_pc_plus4 <= w_pc_plus4;
                    r_id_irq      <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr   = r_pc;
    assign id_instr    = r_id_instr;
    assign id_pc_plus4 = r_id_pc_plus4;
    assign id_irq      = r_id_irq;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_if_stage: vector table, corner sequences and random run vs model. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset, irq, stall, except, jump, jump_reg, branch_taken;
    logic [25:0] jump_target;
    logic [31:0] jr_target, branch_target;
    logic [31:0] imem_addr, imem_rdata, id_instr, id_pc_plus4;
    logic        id_irq;

    always #5 clk = ~clk;

    if_stage dut (
        .clk           (clk),
        .reset         (reset),
        .irq           (irq),
        .stall         (stall),
        .except        (except),
        .jump          (jump),
        .jump_reg      (jump_reg),
        .jump_target   (jump_target),
        .jr_target     (jr_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .id_instr      (id_instr),
        .id_pc_plus4   (id_pc_plus4),
        .id_irq        (id_irq)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    assign imem_rdata = rom(imem_addr);

    typedef struct {
        logic        rst, irq, stall, exc, jmp, jreg, br;
        logic [25:0] jt;
        logic [31:0] jr, bt;
    } in_t;

    typedef struct {
        in_t         in;
        logic [31:0] pc, instr, pp4;
        logic        irq;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference state: what the stage should hold after each edge.
    logic [31:0] m_pc = 32'h0, m_instr = 32'h0, m_pp4 = 32'h0;
    logic        m_irq = 1'b0, m_pend = 1'b0;

    function automatic in_t idle();
        in_t v;
        v = '{rst: 1'b0, irq: 1'b0, stall: 1'b0, exc: 1'b0, jmp: 1'b0,
              jreg: 1'b0, br: 1'b0, jt: 26'h0, jr: 32'h0, bt: 32'h0};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input in_t v);
        logic [31:0] seq_pc;
        logic        user;
        seq_pc = {m_pc[31], m_pc[30:0] + 31'd4};
        user   = !m_pc[31];
        if (v.rst) begin
            m_pc = 32'h8000_0000; m_pend = 1'b0;
            m_instr = 32'h0; m_pp4 = 32'h0; m_irq = 1'b0;
        end else if (v.br || v.exc || v.jmp) begin
            m_pend = m_pend | (v.irq & user);
            if (v.br)        m_pc = v.bt;
            else if (v.exc)  m_pc = 32'h8000_0008;
            else if (v.jreg) m_pc = v.jr;
            else             m_pc = {m_pp4[31:28], v.jt, 2'b00};
            m_instr = 32'h0; m_pp4 = 32'h0; m_irq = 1'b0;
        end else if (v.stall) begin
            m_pend = m_pend | (v.irq & user);
        end else if (m_pend && user) begin
            m_instr = 32'h0; m_pp4 = m_pc; m_irq = 1'b1;
            m_pc = 32'h8000_0004; m_pend = 1'b0;
        end else begin
            m_pend = m_pend | (v.irq & user);
            m_instr = rom(m_pc); m_pp4 = seq_pc; m_irq = 1'b0; m_pc = seq_pc;
        end
    endtask

    task automatic apply(input in_t v);
        @(negedge clk);
        reset = v.rst; irq = v.irq; stall = v.stall; except = v.exc;
        jump = v.jmp; jump_reg = v.jreg; branch_taken = v.br;
        jump_target = v.jt; jr_target = v.jr; branch_target = v.bt;
        model_step(v);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".pc"},    imem_addr,           m_pc);
        check({tag, ".instr"}, id_instr,            m_instr);
        check({tag, ".pp4"},   id_pc_plus4,         m_pp4);
        check({tag, ".irq"},   {31'h0, id_irq},     {31'h0, m_irq});
    endtask

    task automatic add_row(input in_t v, input logic [31:0] pc, input logic [31:0] instr,
                           input logic [31:0] pp4, input logic irqv);
        vec_t r;
        r.in = v; r.pc = pc; r.instr = instr; r.pp4 = pp4; r.irq = irqv;
        tbl.push_back(r);
    endtask

    initial begin
        in_t v;
        reset = 1'b1; irq = 1'b0; stall = 1'b0; except = 1'b0; jump = 1'b0;
        jump_reg = 1'b0; branch_taken = 1'b0; jump_target = 26'h0;
        jr_target = 32'h0; branch_target = 32'h0;

        // Directed vector table: {inputs for one cycle, state after the edge}.
        v = idle(); v.rst = 1'b1;
        add_row(v, 32'h8000_0000, 32'h0, 32'h0, 1'b0);
        v = idle();
        add_row(v, 32'h8000_0004, rom(32'h8000_0000), 32'h8000_0004, 1'b0);
        add_row(v, 32'h8000_0008, rom(32'h8000_0004), 32'h8000_0008, 1'b0);
        v = idle(); v.br = 1'b1; v.bt = 32'h0000_000C;
        add_row(v, 32'h0000_000C, 32'h0, 32'h0, 1'b0);
        v = idle();
        add_row(v, 32'h0000_0010, rom(32'h0000_000C), 32'h0000_0010, 1'b0);
        v = idle(); v.stall = 1'b1;
        add_row(v, 32'h0000_0010, rom(32'h0000_000C), 32'h0000_0010, 1'b0);
        add_row(v, 32'h0000_0010, rom(32'h0000_000C), 32'h0000_0010, 1'b0);
        v = idle();
        add_row(v, 32'h0000_0014, rom(32'h0000_0010), 32'h0000_0014, 1'b0);
        v = idle(); v.br = 1'b1; v.bt = 32'h0000_0100; v.stall = 1'b1;
        add_row(v, 32'h0000_0100, 32'h0, 32'h0, 1'b0);
        v = idle();
        add_row(v, 32'h0000_0104, rom(32'h0000_0100), 32'h0000_0104, 1'b0);
        v = idle(); v.exc = 1'b1; v.jmp = 1'b1; v.jt = 26'h3FF;
        add_row(v, 32'h8000_0008, 32'h0, 32'h0, 1'b0);
        v = idle(); v.br = 1'b1; v.bt = 32'h0000_001C; v.exc = 1'b1;
        add_row(v, 32'h0000_001C, 32'h0, 32'h0, 1'b0);
        v = idle(); v.irq = 1'b1;
        add_row(v, 32'h0000_0020, rom(32'h0000_001C), 32'h0000_0020, 1'b0);
        v = idle();
        add_row(v, 32'h8000_0004, 32'h0, 32'h0000_0020, 1'b1);
        v = idle(); v.irq = 1'b1;
        add_row(v, 32'h8000_0008, rom(32'h8000_0004), 32'h8000_0008, 1'b0);
        v = idle();
        add_row(v, 32'h8000_000C, rom(32'h8000_0008), 32'h8000_000C, 1'b0);
        v = idle(); v.br = 1'b1; v.bt = 32'h7FFF_FFFC;
        add_row(v, 32'h7FFF_FFFC, 32'h0, 32'h0, 1'b0);
        v = idle();
        add_row(v, 32'h0000_0000, rom(32'h7FFF_FFFC), 32'h0000_0000, 1'b0);
        v = idle(); v.br = 1'b1; v.bt = 32'hFFFF_FFFC;
        add_row(v, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
        v = idle();
        add_row(v, 32'h8000_0000, rom(32'hFFFF_FFFC), 32'h8000_0000, 1'b0);
        v = idle(); v.br = 1'b1; v.bt = 32'h0000_0040;
        add_row(v, 32'h0000_0040, 32'h0, 32'h0, 1'b0);
        v = idle();
        add_row(v, 32'h0000_0044, rom(32'h0000_0040), 32'h0000_0044, 1'b0);
        v = idle(); v.jmp = 1'b1; v.jt = 26'h0000123;
        add_row(v, 32'h0000_048C, 32'h0, 32'h0, 1'b0);
        v = idle(); v.jmp = 1'b1; v.jreg = 1'b1; v.jr = 32'h0000_0200; v.jt = 26'h55;
        add_row(v, 32'h0000_0200, 32'h0, 32'h0, 1'b0);
        v = idle();
        add_row(v, 32'h0000_0204, rom(32'h0000_0200), 32'h0000_0204, 1'b0);
        v = idle(); v.br = 1'b1; v.bt = 32'h9000_0000;
        add_row(v, 32'h9000_0000, 32'h0, 32'h0, 1'b0);
        v = idle();
        add_row(v, 32'h9000_0004, rom(32'h9000_0000), 32'h9000_0004, 1'b0);
        v = idle(); v.jmp = 1'b1; v.jt = 26'h3FF_FFFF;
        add_row(v, 32'h9FFF_FFFC, 32'h0, 32'h0, 1'b0);
        v = idle(); v.br = 1'b1; v.bt = 32'h0000_0060;
        add_row(v, 32'h0000_0060, 32'h0, 32'h0, 1'b0);
        v = idle(); v.irq = 1'b1;
        add_row(v, 32'h0000_0064, rom(32'h0000_0060), 32'h0000_0064, 1'b0);
        v = idle(); v.stall = 1'b1;
        add_row(v, 32'h0000_0064, rom(32'h0000_0060), 32'h0000_0064, 1'b0);
        v = idle();
        add_row(v, 32'h8000_0004, 32'h0, 32'h0000_0064, 1'b1);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].in);
            check($sformatf("row%0d.pc", i),    imem_addr,       tbl[i].pc);
            check($sformatf("row%0d.instr", i), id_instr,        tbl[i].instr);
            check($sformatf("row%0d.pp4", i),   id_pc_plus4,     tbl[i].pp4);
            check($sformatf("row%0d.irq", i),   {31'h0, id_irq}, {31'h0, tbl[i].irq});
        end

        // Reset while an interrupt is pending drops the request.
        v = idle(); v.br = 1'b1; v.bt = 32'h0000_0030;
        apply(v); check_model("rp_br");
        v = idle(); v.irq = 1'b1; v.stall = 1'b1;
        apply(v); check_model("rp_pend");
        v = idle(); v.rst = 1'b1;
        apply(v); check_model("rp_rst");
        check("rp_rst_pc", imem_addr, 32'h8000_0000);
        v = idle(); v.br = 1'b1; v.bt = 32'h0000_0050;
        apply(v); check_model("rp_user");
        v = idle();
        apply(v); check_model("rp_seq1");
        check("rp_no_irq_pc", imem_addr, 32'h0000_0054);
        check("rp_no_irq", {31'h0, id_irq}, 32'h0);
        apply(v); check_model("rp_seq2");

        // Randomised run against the reference model.
        for (int i = 0; i < 600; i++) begin
            v = idle();
            v.rst   = ($urandom_range(0, 59) == 0);
            v.irq   = ($urandom_range(0, 4) == 0);
            v.stall = ($urandom_range(0, 4) == 0);
            v.br    = ($urandom_range(0, 9) == 0);
            v.exc   = ($urandom_range(0, 15) == 0);
            v.jmp   = ($urandom_range(0, 9) == 0);
            v.jreg  = $urandom_range(0, 1) == 1;
            v.jt    = 26'($urandom);
            v.jr    = $urandom & 32'hFFFF_FFFC;
            v.bt    = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 1) == 1) v.bt[31] = 1'b0;
            if ($urandom_range(0, 7) == 0) v.bt = {v.bt[31], 31'h7FFF_FFF8};
            apply(v);
            check_model($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage pipelined processor: holds the program counter, addresses the instruction ROM, selects the next PC from sequential, branch, jump, register-jump, interrupt and exception sources, and loads the IF/ID pipeline register that feeds the ID-stage decoder. It also turns an external interrupt request into a tagged fetch slot, so ID can write the return address to `$k0`. The PC bit 31 is the kernel/supervisor bit.

## Interface
- `RESET_PC`, default `32'h8000_0000`: PC value after reset.
- `ILLOP_PC`, default `32'h8000_0004`: interrupt vector.
- `XADR_PC`, default `32'h8000_0008`: exception vector.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `irq` input 1: level interrupt request from the peripheral block.
- `stall` input 1: load-use hold from the hazard unit.
- `except` input 1: ID decoder flags an undefined opcode.
- `jump` input 1: ID holds j/jal/jr/jalr.
- `jump_reg` input 1: qualifies `jump` as jr/jalr.
- `jump_target` input 26: ID instruction[25:0].
- `jr_target` input 32: forwarded rs value.
- `branch_taken` input 1: EX resolved a branch as taken.
- `branch_target` input 32: EX-computed branch address.
- `imem_addr` output 32: equals current PC.
- `imem_rdata` input 32: combinational ROM data for `imem_addr`.
- `id_instr` output 32: IF/ID instruction.
- `id_pc_plus4` output 32: IF/ID return-address field.
- `id_irq` output 1: IF/ID slot is an interrupt slot.

## Operation
- Registers: `pc`, `irq_pending`, and IF/ID (`id_instr`, `id_pc_plus4`, `id_irq`).
- `pc_plus4 = {pc[31], pc[30:0] + 31'd4}`. The carry never touches bit 31.
- Jump target = `{pc_plus4[31:28], jump_target, 2'b00}`. It is formed from the ID-stage PC, `id_pc_plus4`.
- `irq_pending` set: `irq` high while `pc[31]==0`.
- `irq_pending` clear: when the interrupt slot is launched, or on reset.
- `irq` is ignored while `pc[31]==1`; no nesting.
- Next-PC priority, highest first:
  1. `reset` → `RESET_PC`.
  2. `branch_taken` → `branch_target`.
  3. `except` → `XADR_PC`.
  4. `jump & jump_reg` → `jr_target`.
  5. `jump` → jump target.
  6. `stall` → hold `pc`.
  7. Interrupt take (`irq_pending & ~pc[31]`) → `ILLOP_PC`.
  8. Otherwise → `pc_plus4`.
- Redirect (sources 2–5) loads IF/ID with a bubble: `id_instr = 0` (nop), `id_irq = 0`, `id_pc_plus4 = 0`.
- A redirect also overrides `stall`: flushing wins over holding.
- Stall with no redirect: `pc` and IF/ID both hold; `irq_pending` may still set.
- Interrupt take:
  - The fetched word is discarded.
  - IF/ID gets `id_instr = 0`, `id_irq = 1`, `id_pc_plus4 = pc`.
  - `pc` is the PC of the unexecuted instruction, i.e. the return address.
- Normal fetch: `id_instr = imem_rdata`, `id_pc_plus4 = pc_plus4`, `id_irq = 0`.
- Reset values: `pc = RESET_PC`, `irq_pending = 0`, `id_instr = 0`, `id_pc_plus4 = 0`, `id_irq = 0`.

## Timing
- Fetch latency: one cycle. The word at `pc` appears on `id_instr` the cycle after `pc` is presented.
- Redirect: a target driven in cycle N is `pc` in cycle N+1. Its instruction reaches `id_instr` in N+2.
- Branch penalty: two bubbles (flush of IF/ID, plus the ID-stage kill done by the downstream register).
- Jump penalty: one bubble.
- Interrupt latency:
  - `irq` sampled in cycle N.
  - Earliest take is N+1 (`irq_pending` registered), subject to the priority list.
  - `id_irq` pulses for exactly one cycle.
- `branch_taken` and `except` in the same cycle: branch wins. The excepting instruction is on the wrong path.
- Reset asserted mid-stall or mid-interrupt: everything returns to reset values on the next edge, and the pending interrupt is dropped.
- Wrap: `pc = 32'h7FFF_FFFC` → `pc_plus4 = 32'h0000_0000`. `pc = 32'hFFFF_FFFC` → `32'h8000_0000`.

## Structure
- Shared package `cpu_pkg`: `RESET_PC`, `ILLOP_PC`, `XADR_PC`, and `NOP_INSTR = 32'h0`.
- The package also holds a 3-bit `pc_src_t` enum: SEQ, BRANCH, JUMP, JREG, IRQ, EXC, HOLD. The enum is shared with the debug tracer.
- One sub-module: `pc_mux`, combinational. It takes the priority inputs and produces `pc_src_t` plus the next PC.
- Registers stay in `if_stage`.

## Test plan
- Reset, then run 3 cycles: `imem_addr` sequence is `80000000 → 80000004 → 80000008`. `id_pc_plus4` lags by one cycle and starts at `80000004`.
- `pc = 00000010`, assert `stall` for 2 cycles: `pc` and `id_instr` are frozen for both cycles. `pc = 00000014` the cycle after release.
- `branch_taken = 1`, `branch_target = 00000100` together with `stall = 1`: next `pc = 00000100` and `id_instr = 0`.
- `pc = 00000020`, pulse `irq`: one cycle after pending, `pc = 80000004`, `id_irq = 1`, `id_pc_plus4 = 00000020`. A further `irq` while in kernel space is ignored.
- `except` and `jump` together: next `pc = 80000008`.
- `branch_taken` and `except` together: next `pc = branch_target`.
- `pc = 7FFFFFFC`, sequential fetch: next `pc = 00000000`.
- `reset` during `irq_pending = 1`: `pc = 80000000`, and no `id_irq` pulse follows.
